// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard scheduler.
//   REG_AW      : register address width
//   FWD_*       : 2-bit EX operand-select encodings
//   stage_tag_t : shadow tag {dst, we, ld} kept per pipeline stage
//   writes()    : stage really writes a register (r0 never counts)
//   src_hit()   : a used source matches a writing stage
//   fwd_sel()   : MEM-over-WB forwarding priority for one EX source
package hazard_pkg;

   localparam int unsigned REG_AW = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic [REG_AW-1:0] dst;
      logic              we;
      logic              ld;
   } stage_tag_t;

   // A write to r0 is discarded by the register file, so it never creates a dependency.
   function automatic logic writes(input stage_tag_t t);
      return t.we && (t.dst != '0);
   endfunction

   function automatic logic src_hit(input logic uses, input logic [REG_AW-1:0] src,
                                    input stage_tag_t t);
      return uses && writes(t) && (src == t.dst);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                          input stage_tag_t mem, input stage_tag_t wb);
      if (src_hit(1'b1, src, mem)) return FWD_MEM;
      if (src_hit(1'b1, src, wb))  return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_stage_tag.sv
// hazard_stage_tag: one shadow pipeline-stage tag register.
//   clk, rst_n : clock, asynchronous active-low reset (clears the tag)
//   clear      : synchronous clear, loads an all-zero tag (bubble)
//   d, q       : next / current stage tag
module hazard_stage_tag
   import hazard_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  stage_tag_t d,
   output stage_tag_t q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     q <= '0;
      else if (clear) q <= '0;
      else            q <= d;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline hazard scheduler.
// Tracks shadow tags of the instructions in EX/MEM/WB and produces the IF/ID
// stall, ID/EX bubble, IF/ID flush and EX forwarding selects.
//   Inputs : clk, rst_n (async, active low), ID decode fields (id_valid, id_rs,
//            id_rt, id_uses_rs, id_uses_rt, id_dst, id_regwrite, id_memread),
//            ex_branch_taken from EX branch resolution.
//   Outputs: stall_if_id, bubble_ex, flush_if_id, fwd_a, fwd_b (00 regfile,
//            01 EX/MEM, 10 MEM/WB), stall_count (saturating stall cycles).
// Build option: define HAZARD_FORWARD_EN to enable forwarding (only load-use
// stalls). Undefined, fwd_a/fwd_b stay 00 and any EX or MEM writer of an ID
// source stalls.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              ex_branch_taken,
   output logic              stall_if_id,
   output logic              bubble_ex,
   output logic              flush_if_id,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_count
);

   stage_tag_t        ex_d, ex_q, mem_q, wb_d, wb_q;
   logic [REG_AW-1:0] ex_rs, ex_rt;
   logic              hit_ex, hazard, stall_int, bubble_int;
   logic [1:0]        fwd_a_int, fwd_b_int;
   logic              unused_tags;

   always_comb begin
      ex_d = '{dst: id_dst, we: id_regwrite & id_valid, ld: id_memread & id_valid};
      wb_d = '{dst: mem_q.dst, we: mem_q.we, ld: 1'b0};
   end

   hazard_stage_tag u_ex  (.clk(clk), .rst_n(rst_n), .clear(bubble_int), .d(ex_d),  .q(ex_q));
   hazard_stage_tag u_mem (.clk(clk), .rst_n(rst_n), .clear(1'b0),       .d(ex_q),  .q(mem_q));
   hazard_stage_tag u_wb  (.clk(clk), .rst_n(rst_n), .clear(1'b0),       .d(wb_d),  .q(wb_q));

   // EX source addresses travel alongside the EX tag for forwarding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_rs <= '0;
         ex_rt <= '0;
      end else if (bubble_int) begin
         ex_rs <= '0;
         ex_rt <= '0;
      end else begin
         ex_rs <= id_rs;
         ex_rt <= id_rt;
      end
   end

   always_comb begin
      hit_ex = id_valid && (src_hit(id_uses_rs, id_rs, ex_q) || src_hit(id_uses_rt, id_rt, ex_q));
`ifdef HAZARD_FORWARD_EN
      hazard      = hit_ex && ex_q.ld;
      fwd_a_int   = fwd_sel(ex_rs, mem_q, wb_q);
      fwd_b_int   = fwd_sel(ex_rt, mem_q, wb_q);
      unused_tags = mem_q.ld ^ wb_q.ld;
`else
      hazard      = hit_ex || (id_valid && (src_hit(id_uses_rs, id_rs, mem_q) ||
                                            src_hit(id_uses_rt, id_rt, mem_q)));
      fwd_a_int   = FWD_RF;
      fwd_b_int   = FWD_RF;
      unused_tags = ^{ex_rs, ex_rt, mem_q.ld, wb_q};
`endif
      // A taken branch squashes the ID instruction, so it wins over any stall.
      stall_int  = hazard && !ex_branch_taken;
      bubble_int = hazard || ex_branch_taken;
   end

   // Outputs are forced low while reset is held, including a flush requested by EX.
   always_comb begin
      stall_if_id = rst_n & stall_int;
      bubble_ex   = rst_n & bubble_int;
      flush_if_id = rst_n & ex_branch_taken;
      fwd_a       = rst_n ? fwd_a_int : FWD_RF;
      fwd_b       = rst_n ? fwd_b_int : FWD_RF;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_count <= '0;
      else if (stall_int && (stall_count != '1))
         stall_count <= stall_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// Drives ID decode fields cycle by cycle (holding the ID instruction while a
// stall is expected, as the real IF/ID register would) and compares
// {stall, bubble, flush, fwd_a, fwd_b} and stall_count against hand-derived values.
// Works in both builds; build-specific expectations follow HAZARD_FORWARD_EN.
module tb_hazard_ctrl;

   localparam int unsigned CW = 4;
`ifdef HAZARD_FORWARD_EN
   localparam int SPP = 1;   // stall cycles per load-use pair
`else
   localparam int SPP = 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
   logic [4:0]    id_rs, id_rt, id_dst;
   logic          ex_branch_taken = 1'b0;
   logic          stall_if_id, bubble_ex, flush_if_id;
   logic [1:0]    fwd_a, fwd_b;
   logic [CW-1:0] stall_count;
   logic [6:0]    obs;

   int checks = 0;
   int failures = 0;
   int exp_count = 0;

   always #5 clk = ~clk;

   // {stall, bubble, flush, fwd_a, fwd_b}
   assign obs = {stall_if_id, bubble_ex, flush_if_id, fwd_a, fwd_b};

   hazard_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_regwrite(id_regwrite), .id_memread(id_memread),
      .ex_branch_taken(ex_branch_taken), .stall_if_id(stall_if_id),
      .bubble_ex(bubble_ex), .flush_if_id(flush_if_id), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_count(stall_count)
   );

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dst,
                         input logic rw, input logic mr);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_dst = dst; id_regwrite = rw; id_memread = mr;
   endtask

   task automatic nop_id();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      nop_id();
      repeat (3) tick();
   endtask

   task automatic test_reset();
      set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
      ex_branch_taken = 1'b1;
      #3;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL reset_outputs: got %b expected %b", obs, 7'b0000000);
      end
      checks++;
      if (stall_count !== '0) begin
         failures++; $display("FAIL reset_count: got %0d expected 0", stall_count);
      end
      ex_branch_taken = 1'b0;
      nop_id();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load_use();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // LW r8
      #1;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL lu_load: got %b expected %b", obs, 7'b0000000);
      end
      tick();
      set_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);  // ADD r10 = r8 + r9
      #1;
      checks++;
      if (obs !== 7'b1100000) begin
         failures++; $display("FAIL lu_stall1: got %b expected %b", obs, 7'b1100000);
      end
      tick(); exp_count++;
`ifdef HAZARD_FORWARD_EN
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL lu_release: got %b expected %b", obs, 7'b0000000);
      end
      tick();
      nop_id(); #1;
      checks++;
      if (obs !== 7'b0001000) begin
         failures++; $display("FAIL lu_fwd_wb: got %b expected %b", obs, 7'b0001000);
      end
`else
      checks++;
      if (obs !== 7'b1100000) begin
         failures++; $display("FAIL lu_stall2: got %b expected %b", obs, 7'b1100000);
      end
      tick(); exp_count++;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL lu_release: got %b expected %b", obs, 7'b0000000);
      end
      tick();
      nop_id(); #1;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL lu_nofwd: got %b expected %b", obs, 7'b0000000);
      end
`endif
      checks++;
      if (stall_count !== CW'(exp_count)) begin
         failures++; $display("FAIL lu_count: got %0d expected %0d", stall_count, exp_count);
      end
      drain();
   endtask

`ifdef HAZARD_FORWARD_EN
   task automatic test_alu_chain();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // ADD r3
      tick();
      set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // SUB r4 = r3 - r3
      #1;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL alu_nostall: got %b expected %b", obs, 7'b0000000);
      end
      tick();
      set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);   // AND r5 reads r3
      #1;
      checks++;
      if (obs !== 7'b0000101) begin
         failures++; $display("FAIL alu_fwd_mem: got %b expected %b", obs, 7'b0000101);
      end
      tick();
      nop_id(); #1;
      checks++;
      if (obs !== 7'b0001000) begin
         failures++; $display("FAIL alu_fwd_wb: got %b expected %b", obs, 7'b0001000);
      end
      checks++;
      if (stall_count !== CW'(exp_count)) begin
         failures++; $display("FAIL alu_count: got %0d expected %0d", stall_count, exp_count);
      end
      drain();
   endtask
`else
   task automatic test_no_forward();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);   // ADD r2
      tick();
      set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);  // OR r11 = r2 | r3
      #1;
      checks++;
      if (obs !== 7'b1100000) begin
         failures++; $display("FAIL nf_stall1: got %b expected %b", obs, 7'b1100000);
      end
      tick(); exp_count++;
      checks++;
      if (obs !== 7'b1100000) begin
         failures++; $display("FAIL nf_stall2: got %b expected %b", obs, 7'b1100000);
      end
      tick(); exp_count++;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL nf_release: got %b expected %b", obs, 7'b0000000);
      end
      tick();
      nop_id(); #1;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL nf_fwd: got %b expected %b", obs, 7'b0000000);
      end
      checks++;
      if (stall_count !== CW'(exp_count)) begin
         failures++; $display("FAIL nf_count: got %0d expected %0d", stall_count, exp_count);
      end
      drain();
      // writer two slots ahead: one stall cycle while it sits in MEM
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);   // ADD r2
      tick();
      set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);  // XOR r12
      tick();
      set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);  // OR reads r2
      #1;
      checks++;
      if (obs !== 7'b1100000) begin
         failures++; $display("FAIL nf_gap_stall: got %b expected %b", obs, 7'b1100000);
      end
      tick(); exp_count++;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL nf_gap_release: got %b expected %b", obs, 7'b0000000);
      end
      drain();
      checks++;
      if (stall_count !== CW'(exp_count)) begin
         failures++; $display("FAIL nf_gap_count: got %0d expected %0d", stall_count, exp_count);
      end
   endtask
`endif

   task automatic test_zero_reg();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);   // ADD r0
      tick();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // ADD r6 = r0 + r0
      #1;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL zero_nostall: got %b expected %b", obs, 7'b0000000);
      end
      tick();
      nop_id(); #1;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL zero_fwd: got %b expected %b", obs, 7'b0000000);
      end
      drain();
   endtask

   task automatic test_invalid();
      set_id(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);   // invalid load of r7
      #1;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL inv_id: got %b expected %b", obs, 7'b0000000);
      end
      tick();
      set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);   // reads r7
      #1;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL inv_ex_zero: got %b expected %b", obs, 7'b0000000);
      end
      drain();
   endtask

   task automatic test_branch();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // LW r8
      tick();
      set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);  // ADD reads r8
      ex_branch_taken = 1'b1;
      #1;
      checks++;
      if (obs !== 7'b0110000) begin
         failures++; $display("FAIL br_override: got %b expected %b", obs, 7'b0110000);
      end
      tick();
      ex_branch_taken = 1'b0;
      nop_id(); #1;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL br_after: got %b expected %b", obs, 7'b0000000);
      end
      checks++;
      if (stall_count !== CW'(exp_count)) begin
         failures++; $display("FAIL br_count: got %0d expected %0d", stall_count, exp_count);
      end
      drain();
   endtask

   task automatic test_reset_mid_stall();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // LW r8
      tick();
      set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
      #1;
      checks++;
      if (obs !== 7'b1100000) begin
         failures++; $display("FAIL rst_pre: got %b expected %b", obs, 7'b1100000);
      end
      #1;
      rst_n = 1'b0;
      ex_branch_taken = 1'b1;
      #1;
      exp_count = 0;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL rst_outputs: got %b expected %b", obs, 7'b0000000);
      end
      checks++;
      if (stall_count !== CW'(exp_count)) begin
         failures++; $display("FAIL rst_count: got %0d expected %0d", stall_count, exp_count);
      end
      ex_branch_taken = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (obs !== 7'b0000000) begin
         failures++; $display("FAIL rst_discard: got %b expected %b", obs, 7'b0000000);
      end
      tick();
      drain();
      checks++;
      if (stall_count !== CW'(exp_count)) begin
         failures++; $display("FAIL rst_post_count: got %0d expected %0d", stall_count, exp_count);
      end
   endtask

   task automatic load_use_pair();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1);  // LW r12
      tick();
      set_id(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0); // reads r12
      repeat (SPP) tick();
      tick();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 14 / SPP; i++) load_use_pair();
      drain();
      exp_count = 14;
      checks++;
      if (stall_count !== CW'(exp_count)) begin
         failures++; $display("FAIL sat_preload: got %0d expected %0d", stall_count, exp_count);
      end
      for (int i = 0; i < 3; i++) load_use_pair();
      drain();
      exp_count = 15;
      checks++;
      if (stall_count !== CW'(exp_count)) begin
         failures++; $display("FAIL sat_hold: got %0d expected %0d", stall_count, exp_count);
      end
   endtask

   initial begin
      nop_id();
      test_reset();
      test_load_use();
`ifdef HAZARD_FORWARD_EN
      test_alu_chain();
`else
      test_no_forward();
`endif
      test_zero_reg();
      test_invalid();
      test_branch();
      test_reset_mid_stall();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
